// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble insertion and multdiv sequencing.
// Optional HAZARD_PERF_CNT_EN adds load-use and multdiv stall-cycle counters.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_inst,
  input  logic [31:0] dx_inst,
  input  logic        branch_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        flush_fd,
  output logic        flush_dx,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_result_sel,
`ifdef HAZARD_PERF_CNT_EN
  output logic        md_err,
  output logic [31:0] lu_stall_count,
  output logic [31:0] md_stall_count
`else
  output logic        md_err
`endif
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MD_START, MD_WAIT, MD_DONE} mdStateT;

  mdStateT          state, nextState;
  logic [CNT_W-1:0] waitCnt, nextWaitCnt;
  logic             errLatch, nextErrLatch;
  logic             opIsDiv, nextOpIsDiv;

  logic [4:0] fdOp, fdRd, fdRs, fdRt, dxOp, dxRd, dxAlu;
  logic       fdReadsRs, fdReadsRt, fdReadsRd;
  logic       loadUse, dxIsMul, dxIsDiv, mdBusy, luActed;
  logic       unusedBits;

  assign fdOp  = fd_inst[31:27];
  assign fdRd  = fd_inst[26:22];
  assign fdRs  = fd_inst[21:17];
  assign fdRt  = fd_inst[16:12];
  assign dxOp  = dx_inst[31:27];
  assign dxRd  = dx_inst[26:22];
  assign dxAlu = dx_inst[6:2];
  assign unusedBits = ^{dx_inst[21:7], dx_inst[1:0], fd_inst[11:0]};

  assign fdReadsRs = !(fdOp == OP_J || fdOp == OP_JAL || fdOp == OP_SETX);
  assign fdReadsRt = (fdOp == OP_R);
  assign fdReadsRd = (fdOp == OP_SW || fdOp == OP_BNE || fdOp == OP_BLT || fdOp == OP_JR);

  // r0 is hardwired zero, so a load into it can never create a dependency
  assign loadUse = (dxOp == OP_LW) && (dxRd != 5'd0) &&
                   ((fdReadsRs && fdRs == dxRd) ||
                    (fdReadsRt && fdRt == dxRd) ||
                    (fdReadsRd && fdRd == dxRd));

  assign dxIsMul = (dxOp == OP_R) && (dxAlu == ALU_MUL);
  assign dxIsDiv = (dxOp == OP_R) && (dxAlu == ALU_DIV);
  assign mdBusy  = (state == MD_START) || (state == MD_WAIT);
  assign luActed = reset && !branch_taken && (state == IDLE) && loadUse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      errLatch <= 1'b0;
      opIsDiv  <= 1'b0;
    end else begin
      state    <= nextState;
      waitCnt  <= nextWaitCnt;
      errLatch <= nextErrLatch;
      opIsDiv  <= nextOpIsDiv;
    end
  end

  always_comb begin
    nextState    = state;
    nextWaitCnt  = waitCnt;
    nextErrLatch = errLatch;
    nextOpIsDiv  = opIsDiv;
    case (state)
      IDLE: begin
        if ((dxIsMul || dxIsDiv) && !branch_taken) begin
          nextState   = MD_START;
          nextOpIsDiv = dxIsDiv;
        end
      end
      MD_START: begin
        nextWaitCnt  = '0;
        nextErrLatch = 1'b0;
        nextState    = MD_WAIT;
      end
      MD_WAIT: begin
        nextWaitCnt = waitCnt + CNT_W'(1);
        if (md_ready) begin
          nextState    = MD_DONE;
          nextErrLatch = md_exception;
        end else if (waitCnt == TIMEOUT_CNT) begin
          nextState    = MD_DONE;
          nextErrLatch = 1'b1;
        end
      end
      MD_DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Branch redirect outranks the multdiv stall, which outranks load-use
  always_comb begin
    stall_pc      = 1'b0;
    stall_fd      = 1'b0;
    stall_dx      = 1'b0;
    flush_fd      = 1'b0;
    flush_dx      = 1'b0;
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    md_result_sel = 1'b0;
    md_err        = 1'b0;
    if (reset) begin
      if (branch_taken) begin
        flush_fd = 1'b1;
        flush_dx = 1'b1;
      end else if (mdBusy) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        stall_dx = 1'b1;
      end else if (luActed) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        flush_dx = 1'b1;
      end
      ctrl_mult     = (state == MD_START) && !opIsDiv;
      ctrl_div      = (state == MD_START) && opIsDiv;
      md_result_sel = (state == MD_DONE);
      md_err        = (state == MD_DONE) && errLatch;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lu_stall_count <= '0;
      md_stall_count <= '0;
    end else begin
      if (luActed) lu_stall_count <= lu_stall_count + 32'd1;
      if (mdBusy)  md_stall_count <= md_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (load-use, multdiv, branch, reset).
// Define HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_hazard_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fdInst = '0;
  logic [31:0] dxInst = '0;
  logic        branchTaken = 1'b0;
  logic        mdReady = 1'b0;
  logic        mdException = 1'b0;
  logic        stallPc, stallFd, stallDx, flushFd, flushDx;
  logic        ctrlMult, ctrlDiv, mdResultSel, mdErr;
  logic [8:0]  outVec;
  int          checks = 0;
  int          errors = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] luStallCount, mdStallCount;
`endif

  hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .fd_inst(fdInst),
    .dx_inst(dxInst),
    .branch_taken(branchTaken),
    .md_ready(mdReady),
    .md_exception(mdException),
    .stall_pc(stallPc),
    .stall_fd(stallFd),
    .stall_dx(stallDx),
    .flush_fd(flushFd),
    .flush_dx(flushDx),
    .ctrl_mult(ctrlMult),
    .ctrl_div(ctrlDiv),
    .md_result_sel(mdResultSel),
`ifdef HAZARD_PERF_CNT_EN
    .md_err(mdErr),
    .lu_stall_count(luStallCount),
    .md_stall_count(mdStallCount)
`else
    .md_err(mdErr)
`endif
  );

  always #5 clock = ~clock;

  // Bit order: stallPc stallFd stallDx flushFd flushDx ctrlMult ctrlDiv mdResultSel mdErr
  assign outVec = {stallPc, stallFd, stallDx, flushFd, flushDx,
                   ctrlMult, ctrlDiv, mdResultSel, mdErr};

  localparam logic [8:0] NONE    = 9'b000000000;
  localparam logic [8:0] LU      = 9'b110010000;
  localparam logic [8:0] BRANCH  = 9'b000110000;
  localparam logic [8:0] MSTART  = 9'b111001000;
  localparam logic [8:0] DSTART  = 9'b111000100;
  localparam logic [8:0] MWAIT   = 9'b111000000;
  localparam logic [8:0] DONEOK  = 9'b000000010;
  localparam logic [8:0] DONEERR = 9'b000000011;

  function automatic logic [31:0] rType(input logic [4:0] rd, rs, rt, alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] iType(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then settle to the falling edge
  task automatic applyStimulus(input logic [31:0] fd, dx, input logic br, rdy, exc);
    @(posedge clock);
    #1;
    fdInst      = fd;
    dxInst      = dx;
    branchTaken = br;
    mdReady     = rdy;
    mdException = exc;
    @(negedge clock);
  endtask

  logic [31:0] lwR5, lwR0, addUsesR5, mulOp, divOp;

  initial begin
    lwR5      = iType(5'b01000, 5'd5, 5'd2, 17'd0);
    lwR0      = iType(5'b01000, 5'd0, 5'd2, 17'd0);
    addUsesR5 = rType(5'd7, 5'd5, 5'd3, 5'b00000);
    mulOp     = rType(5'd7, 5'd5, 5'd3, 5'b00110);
    divOp     = rType(5'd8, 5'd4, 5'd6, 5'b00111);

    // Hazardous inputs while reset is held must still give quiet outputs
    fdInst = addUsesR5;
    dxInst = lwR5;
    @(negedge clock);
    checkOutput("resetOut", 32'(outVec), 32'(NONE));
    reset = 1'b1;

    applyStimulus(addUsesR5, lwR5, 0, 0, 0);
    checkOutput("luRs", 32'(outVec), 32'(LU));
    applyStimulus(addUsesR5, 32'd0, 0, 0, 0);
    checkOutput("luBubbleNext", 32'(outVec), 32'(NONE));
    applyStimulus(rType(5'd7, 5'd0, 5'd3, 5'b00000), lwR0, 0, 0, 0);
    checkOutput("luR0Exempt", 32'(outVec), 32'(NONE));
    applyStimulus(iType(5'b00111, 5'd5, 5'd1, 17'd0), lwR5, 0, 0, 0);
    checkOutput("luSwRd", 32'(outVec), 32'(LU));
    applyStimulus(rType(5'd7, 5'd3, 5'd5, 5'b00000), lwR5, 0, 0, 0);
    checkOutput("luRt", 32'(outVec), 32'(LU));
    applyStimulus(iType(5'b00101, 5'd7, 5'd3, 17'h05000), lwR5, 0, 0, 0);
    checkOutput("addiNoRt", 32'(outVec), 32'(NONE));
    applyStimulus(iType(5'b00011, 5'd0, 5'd5, 17'd0), lwR5, 0, 0, 0);
    checkOutput("jalNoRs", 32'(outVec), 32'(NONE));
    applyStimulus(addUsesR5, lwR5, 1, 0, 0);
    checkOutput("branchOverLu", 32'(outVec), 32'(BRANCH));

    // mul with result 4 cycles after the start pulse
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("mulIdle", 32'(outVec), 32'(NONE));
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("mulStart", 32'(outVec), 32'(MSTART));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'd0, mulOp, 0, (i == 3), 0);
      checkOutput($sformatf("mulWait%0d", i), 32'(outVec), 32'(MWAIT));
    end
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("mulDone", 32'(outVec), 32'(DONEOK));
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("luCount", luStallCount, 32'd3);
    checkOutput("mdCount", mdStallCount, 32'd5);
`endif

    // Back-to-back mul: one IDLE cycle, then a second start; exception on result
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("mul2Idle", 32'(outVec), 32'(NONE));
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("mul2Start", 32'(outVec), 32'(MSTART));
    applyStimulus(32'd0, mulOp, 0, 1, 1);
    checkOutput("mul2Wait", 32'(outVec), 32'(MWAIT));
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("mul2DoneErr", 32'(outVec), 32'(DONEERR));

    // div that never completes: forced release after 40 wait cycles
    applyStimulus(32'd0, divOp, 0, 0, 0);
    checkOutput("divIdle", 32'(outVec), 32'(NONE));
    applyStimulus(32'd0, divOp, 0, 0, 0);
    checkOutput("divStart", 32'(outVec), 32'(DSTART));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(32'd0, divOp, 0, 0, 0);
      checkOutput($sformatf("divWait%0d", i), 32'(outVec), 32'(MWAIT));
    end
    applyStimulus(32'd0, divOp, 0, 0, 0);
    checkOutput("divTimeoutDone", 32'(outVec), 32'(DONEERR));
    applyStimulus(32'd0, 32'd0, 0, 0, 0);
    checkOutput("divBackIdle", 32'(outVec), 32'(NONE));

    // Reset pulsed mid-wait abandons the op
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("rstMulStart", 32'(outVec), 32'(MSTART));
    applyStimulus(32'd0, mulOp, 0, 0, 0);
    checkOutput("rstMulWait", 32'(outVec), 32'(MWAIT));
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("resetMidWait", 32'(outVec), 32'(NONE));
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("mdCountCleared", mdStallCount, 32'd0);
`endif
    dxInst = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(32'd0, 32'd0, 0, 0, 0);
    checkOutput("noPulseAfterRst", 32'(outVec), 32'(NONE));
    applyStimulus(32'd0, 32'd0, 0, 0, 0);
    checkOutput("stillIdleAfterRst", 32'(outVec), 32'(NONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
